// File: rtl/carry_width_stage_pkg.sv
// -----------------------------------------------------------------------------
// carry_width_stage_pkg
//
// Shared definitions for the carry/width helper stage.
//   adj_mode_e  : which of the three resize cases applies to a given pair of
//                 input/output widths.
//   adj_mode()  : elaboration-time helper that classifies a width pair, so the
//                 resize logic selects its generate branch from one place.
//
// No ports; all datapath widths are parameters of the modules themselves.
// -----------------------------------------------------------------------------
package carry_width_stage_pkg;

    // Resize case chosen purely from the two widths.
    typedef enum logic [1:0] {
        ADJ_TRUNCATE = 2'd0,  // output narrower: keep low bits, drop MSBs
        ADJ_PASS     = 2'd1,  // equal widths: wire straight through
        ADJ_EXTEND   = 2'd2   // output wider: pad upper bits
    } adj_mode_e;

    // Classify a width pair. Evaluated only on constants, so it folds away
    // entirely during elaboration.
    function automatic adj_mode_e adj_mode(input int in_width, input int out_width);
        if (out_width > in_width) begin
            return ADJ_EXTEND;
        end else if (out_width == in_width) begin
            return ADJ_PASS;
        end
        return ADJ_TRUNCATE;
    endfunction

endpackage : carry_width_stage_pkg

// File: rtl/carry_width_stage_if.sv
// -----------------------------------------------------------------------------
// carry_width_stage_if
//
// Bundles the sample inputs and registered results of carry_width_stage.
//
// Signals:
//   in_valid   sample qualifier
//   data_in_a  adder operand A                         [DATA_WIDTH]
//   data_in_b  adder operand B as fed to the adder     [DATA_WIDTH]
//              (already inverted when subtracting)
//   sum        adder result                            [DATA_WIDTH]
//   carry_out  adder final carry-out
//   adj_in     value to resize                         [ADJ_IN_WIDTH]
//   out_valid  registered in_valid
//   carries    carry into each bit position            [DATA_WIDTH]
//   overflow   signed overflow
//   adj_out    resized value                           [ADJ_OUT_WIDTH]
//
// Modports:
//   master  drives the sample, observes the results (the datapath side)
//   slave   the stage itself
// -----------------------------------------------------------------------------
interface carry_width_stage_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADJ_IN_WIDTH  = 1,
    parameter int ADJ_OUT_WIDTH = 16
);

    // Sample side
    logic                     in_valid;
    logic [DATA_WIDTH-1:0]    data_in_a;
    logic [DATA_WIDTH-1:0]    data_in_b;
    logic [DATA_WIDTH-1:0]    sum;
    logic                     carry_out;
    logic [ADJ_IN_WIDTH-1:0]  adj_in;

    // Result side
    logic                     out_valid;
    logic [DATA_WIDTH-1:0]    carries;
    logic                     overflow;
    logic [ADJ_OUT_WIDTH-1:0] adj_out;

    modport master (
        output in_valid,
        output data_in_a,
        output data_in_b,
        output sum,
        output carry_out,
        output adj_in,
        input  out_valid,
        input  carries,
        input  overflow,
        input  adj_out
    );

    modport slave (
        input  in_valid,
        input  data_in_a,
        input  data_in_b,
        input  sum,
        input  carry_out,
        input  adj_in,
        output out_valid,
        output carries,
        output overflow,
        output adj_out
    );

endinterface : carry_width_stage_if

// File: rtl/carry_width_stage_width_adjuster.sv
// -----------------------------------------------------------------------------
// width_adjuster
//
// Purely combinational resize of data_in to OUTPUT_WIDTH bits, working only on
// bit positions:
//   wider    : data_in in the LSBs, upper bits are copies of the input MSB when
//              SIGNED=1, otherwise zero
//   equal    : pass-through
//   narrower : low OUTPUT_WIDTH bits kept, MSBs discarded (wraps, never
//              saturates)
//
// Ports:
//   data_in   value to resize     [INPUT_WIDTH]
//   data_out  resized value       [OUTPUT_WIDTH]
// -----------------------------------------------------------------------------
module width_adjuster
    import carry_width_stage_pkg::*;
#(
    parameter int INPUT_WIDTH  = 1,
    parameter int OUTPUT_WIDTH = 16,
    parameter bit SIGNED       = 1'b0
) (
    input  logic [INPUT_WIDTH-1:0]  data_in,
    output logic [OUTPUT_WIDTH-1:0] data_out
);

    localparam adj_mode_e MODE = adj_mode(INPUT_WIDTH, OUTPUT_WIDTH);

    // Only one branch survives elaboration, so the slices in the other two
    // never have to be legal for this width pair.
    if (MODE == ADJ_EXTEND) begin : g_extend
        localparam int PAD_WIDTH = OUTPUT_WIDTH - INPUT_WIDTH;

        logic fill_bit;

        // Sign-extension replicates the input MSB; zero-extension pads with 0.
        assign fill_bit = SIGNED ? data_in[INPUT_WIDTH-1] : 1'b0;
        assign data_out = {{PAD_WIDTH{fill_bit}}, data_in};

    end else if (MODE == ADJ_PASS) begin : g_pass

        assign data_out = data_in;

    end else begin : g_truncate

        // Plain bit drop: the discarded MSBs are not inspected at all.
        assign data_out = data_in[OUTPUT_WIDTH-1:0];

    end

endmodule : width_adjuster

// File: rtl/carry_width_stage.sv
// -----------------------------------------------------------------------------
// carry_width_stage
//
// Registered helper stage sitting beside the adder/subtractor. For each sample
// with in_valid=1 it captures, one cycle later:
//   carries   the carry into every bit, recovered as a ^ b ^ sum; bit 0 is the
//             adder carry-in
//   overflow  signed overflow = carry into the MSB ^ final carry-out
//   adj_out   adj_in resized to ADJ_OUT_WIDTH by width_adjuster
// Samples with in_valid=0 leave the result registers untouched; out_valid is
// simply in_valid delayed by one cycle. The sum is never cross-checked against
// a + b, so inconsistent operands give the XOR result as-is.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears every output immediately and
//          drops any sample in flight
//   bus    carry_width_stage_if.slave (sample in, registered results out)
// -----------------------------------------------------------------------------
module carry_width_stage
    import carry_width_stage_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADJ_IN_WIDTH  = 1,
    parameter int ADJ_OUT_WIDTH = 16,
    parameter int ADJ_SIGNED    = 0
) (
    input logic               clk,
    input logic               rst_n,
    carry_width_stage_if.slave bus
);

    // -------------------------------------------------------------------------
    // Combinational next-state: depends only on the current sample, never on
    // the registers below.
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]    carries_d;
    logic                     overflow_d;
    logic [ADJ_OUT_WIDTH-1:0] adj_d;

    // Each sum bit is a ^ b ^ carry_in for that position, so XORing the sum
    // back with both operands leaves exactly the carry that entered the bit.
    assign carries_d  = bus.data_in_a ^ bus.data_in_b ^ bus.sum;

    // Signed overflow occurs when the carry into the sign bit differs from
    // the carry out of it.
    assign overflow_d = carries_d[DATA_WIDTH-1] ^ bus.carry_out;

    width_adjuster #(
        .INPUT_WIDTH  (ADJ_IN_WIDTH),
        .OUTPUT_WIDTH (ADJ_OUT_WIDTH),
        .SIGNED       (ADJ_SIGNED != 0)
    ) u_adj (
        .data_in  (bus.adj_in),
        .data_out (adj_d)
    );

    // -------------------------------------------------------------------------
    // Pipeline registers
    // -------------------------------------------------------------------------
    logic                     valid_q;
    logic [DATA_WIDTH-1:0]    carries_q;
    logic                     overflow_q;
    logic [ADJ_OUT_WIDTH-1:0] adj_q;

    // out_valid tracks in_valid every cycle, with no enable.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
        end
    end

    // Result registers load only on a valid sample and otherwise hold.
    // NOTE: these are plain flops, not a memory, so each gets an explicit
    // reset value; outputs are guaranteed zero while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carries_q  <= '0;
            overflow_q <= 1'b0;
            adj_q      <= '0;
        end else if (bus.in_valid) begin
            carries_q  <= carries_d;
            overflow_q <= overflow_d;
            adj_q      <= adj_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs come straight from the registers.
    // -------------------------------------------------------------------------
    assign bus.out_valid = valid_q;
    assign bus.carries   = carries_q;
    assign bus.overflow  = overflow_q;
    assign bus.adj_out   = adj_q;

endmodule : carry_width_stage

// File: tb/tb_carry_width_stage.sv
// -----------------------------------------------------------------------------
// tb_carry_width_stage
//
// Three instances share the same operand stream and differ only in the resize
// configuration:
//   u0 : 1 -> 16, zero-extend
//   u1 : 1 -> 16, sign-extend
//   u2 : 16 -> 8, truncate
// The reference model derives carries by real addition of the operand prefixes
// and overflow from the signed range of the true sum; resize expectations are
// computed as integer values.
// -----------------------------------------------------------------------------
module tb_carry_width_stage;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    carry_width_stage_if #(.DATA_WIDTH(16), .ADJ_IN_WIDTH(1),  .ADJ_OUT_WIDTH(16)) if0 ();
    carry_width_stage_if #(.DATA_WIDTH(16), .ADJ_IN_WIDTH(1),  .ADJ_OUT_WIDTH(16)) if1 ();
    carry_width_stage_if #(.DATA_WIDTH(16), .ADJ_IN_WIDTH(16), .ADJ_OUT_WIDTH(8))  if2 ();

    carry_width_stage #(.DATA_WIDTH(16), .ADJ_IN_WIDTH(1),  .ADJ_OUT_WIDTH(16), .ADJ_SIGNED(0))
        u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    carry_width_stage #(.DATA_WIDTH(16), .ADJ_IN_WIDTH(1),  .ADJ_OUT_WIDTH(16), .ADJ_SIGNED(1))
        u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    carry_width_stage #(.DATA_WIDTH(16), .ADJ_IN_WIDTH(16), .ADJ_OUT_WIDTH(8),  .ADJ_SIGNED(0))
        u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    // ------------------------------------------------------------------ checks
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // ------------------------------------------------------------------ model
    function automatic logic [15:0] model_carries(input logic [15:0] a, input logic [15:0] b,
                                                  input logic cin);
        logic [15:0] c;
        int unsigned ua, ub, mask, part;
        ua = 32'(a);
        ub = 32'(b);
        for (int i = 0; i < 16; i++) begin
            // Carry into bit i is whatever spills out of adding the i low bits.
            mask = (32'd1 << i) - 32'd1;
            part = (ua & mask) + (ub & mask) + 32'(cin);
            c[i] = part[i];
        end
        return c;
    endfunction

    function automatic logic model_overflow(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin);
        int s;
        s = int'($signed(a)) + int'($signed(b)) + int'(cin);
        return (s > 32767) || (s < -32768);
    endfunction

    // Expected results of the sample currently on the inputs.
    logic [15:0] nx_car  = '0;
    logic        nx_ovf  = 1'b0;
    logic [15:0] nx_adj0 = '0;
    logic [15:0] nx_adj1 = '0;
    logic [7:0]  nx_adj2 = '0;

    // Expected registered outputs.
    logic        m_valid = 1'b0;
    logic [15:0] m_car   = '0;
    logic        m_ovf   = 1'b0;
    logic [15:0] m_adj0  = '0;
    logic [15:0] m_adj1  = '0;
    logic [7:0]  m_adj2  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_car   <= '0;
            m_ovf   <= 1'b0;
            m_adj0  <= '0;
            m_adj1  <= '0;
            m_adj2  <= '0;
        end else begin
            m_valid <= if0.in_valid;
            if (if0.in_valid) begin
                m_car  <= nx_car;
                m_ovf  <= nx_ovf;
                m_adj0 <= nx_adj0;
                m_adj1 <= nx_adj1;
                m_adj2 <= nx_adj2;
            end
        end
    end

    // Every cycle, on the falling edge, compare all outputs with the model.
    logic cmp_on = 1'b1;

    always @(negedge clk) begin
        if (cmp_on) begin
            check("cmp.u0.out_valid", 32'(if0.out_valid), 32'(m_valid));
            check("cmp.u0.carries",   32'(if0.carries),   32'(m_car));
            check("cmp.u0.overflow",  32'(if0.overflow),  32'(m_ovf));
            check("cmp.u0.adj_out",   32'(if0.adj_out),   32'(m_adj0));
            check("cmp.u1.adj_out",   32'(if1.adj_out),   32'(m_adj1));
            check("cmp.u1.carries",   32'(if1.carries),   32'(m_car));
            check("cmp.u2.adj_out",   32'(if2.adj_out),   32'(m_adj2));
            check("cmp.u2.out_valid", 32'(if2.out_valid), 32'(m_valid));
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic set_fields(input logic v, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] s, input logic cout, input logic [15:0] adj);
        if0.in_valid = v; if0.data_in_a = a; if0.data_in_b = b; if0.sum = s;
        if0.carry_out = cout; if0.adj_in = adj[0];
        if1.in_valid = v; if1.data_in_a = a; if1.data_in_b = b; if1.sum = s;
        if1.carry_out = cout; if1.adj_in = adj[0];
        if2.in_valid = v; if2.data_in_a = a; if2.data_in_b = b; if2.sum = s;
        if2.carry_out = cout; if2.adj_in = adj;
    endtask

    // Valid sample with explicit sum and hand-supplied expected carry results.
    task automatic drive_raw(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s,
                             input logic cout, input logic [15:0] adj,
                             input logic [15:0] exp_car, input logic exp_ovf);
        set_fields(1'b1, a, b, s, cout, adj);
        nx_car  = exp_car;
        nx_ovf  = exp_ovf;
        nx_adj0 = adj[0] ? 16'd1 : 16'd0;        // value 0 or 1
        nx_adj1 = adj[0] ? 16'hFFFF : 16'h0000;  // value 0 or -1
        nx_adj2 = 8'(adj % 16'd256);             // value modulo 2^8
    endtask

    // Valid sample produced by a real addition a + b + cin.
    task automatic drive_add(input logic [15:0] a, input logic [15:0] b, input logic cin,
                             input logic [15:0] adj);
        logic [16:0] full;
        full = 17'(a) + 17'(b) + 17'(cin);
        drive_raw(a, b, full[15:0], full[16], adj, model_carries(a, b, cin),
                  model_overflow(a, b, cin));
    endtask

    // Step to just after the next falling edge (away from the active edge).
    task automatic next();
        @(negedge clk);
        #1;
    endtask

    // Hand-computed literal expectations for the previously driven sample.
    task automatic lit(input string tag, input logic [15:0] car, input logic ovf,
                       input logic [15:0] adj0, input logic [15:0] adj1, input logic [7:0] adj2);
        check({tag, ".out_valid"}, 32'(if0.out_valid), 32'd1);
        check({tag, ".carries"},   32'(if0.carries),   32'(car));
        check({tag, ".overflow"},  32'(if0.overflow),  32'(ovf));
        check({tag, ".adj0"},      32'(if0.adj_out),   32'(adj0));
        check({tag, ".adj1"},      32'(if1.adj_out),   32'(adj1));
        check({tag, ".adj2"},      32'(if2.adj_out),   32'(adj2));
    endtask

    task automatic expect_zero(input string tag);
        check({tag, ".out_valid"}, 32'(if0.out_valid), 32'd0);
        check({tag, ".carries"},   32'(if0.carries),   32'd0);
        check({tag, ".overflow"},  32'(if0.overflow),  32'd0);
        check({tag, ".adj0"},      32'(if0.adj_out),   32'd0);
        check({tag, ".adj1"},      32'(if1.adj_out),   32'd0);
        check({tag, ".adj2"},      32'(if2.adj_out),   32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_fields(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0);
        #2;
        expect_zero("reset");
        repeat (2) next();
        rst_n = 1'b1;

        // Carry ripples through bits 1..8.
        drive_add(16'h00FF, 16'h0001, 1'b0, 16'h0001);
        next();
        lit("chain", 16'h01FE, 1'b0, 16'h0001, 16'hFFFF, 8'h01);

        // Positive + positive wraps negative.
        drive_add(16'h7FFF, 16'h0001, 1'b0, 16'hABCD);
        next();
        lit("ovf", 16'hFFFE, 1'b1, 16'h0001, 16'hFFFF, 8'hCD);

        // 5 - 3 as 5 + ~3 + 1: carry into bit 2 is 0 (1 + 0 + 1 = 2 fits in
        // two bits), every other position carries.
        drive_add(16'h0005, 16'hFFFC, 1'b1, 16'h0000);
        next();
        lit("sub", 16'hFFFB, 1'b0, 16'h0000, 16'h0000, 8'h00);

        // Inconsistent sum: result is still the plain XOR.
        drive_raw(16'h1234, 16'h0000, 16'hFFFF, 1'b0, 16'h00FE, 16'hEDCB, 1'b1);
        next();
        lit("garbage", 16'hEDCB, 1'b1, 16'h0000, 16'h0000, 8'hFE);

        // in_valid=0 with different inputs: results hold, out_valid drops.
        set_fields(1'b0, 16'hFFFF, 16'hFFFF, 16'h1111, 1'b1, 16'h5555);
        next();
        check("hold.out_valid", 32'(if0.out_valid), 32'd0);
        check("hold.carries",   32'(if0.carries),   32'h0000EDCB);
        check("hold.overflow",  32'(if0.overflow),  32'd1);
        check("hold.adj2",      32'(if2.adj_out),   32'h000000FE);
        next();

        // Negative + negative: no internal carries, carry-out only.
        drive_add(16'h8000, 16'h8000, 1'b0, 16'h0001);
        next();
        lit("negneg", 16'h0000, 1'b1, 16'h0001, 16'hFFFF, 8'h01);

        // Back-to-back samples every cycle.
        drive_add(16'hFFFF, 16'h0001, 1'b0, 16'h0080);
        next();
        drive_add(16'hFFFF, 16'hFFFF, 1'b1, 16'hFF7F);
        next();
        drive_add(16'h8000, 16'hFFFF, 1'b0, 16'h1234);
        next();
        drive_add(16'h4000, 16'h4000, 1'b0, 16'h8001);
        next();
        drive_add(16'hA5A5, 16'h5A5A, 1'b1, 16'h00FF);
        next();
        lit("b2b", 16'hFFFF, 1'b0, 16'h0001, 16'hFFFF, 8'hFF);

        // Reset asserted mid-cycle with a sample in flight.
        drive_add(16'h00FF, 16'h0001, 1'b0, 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        expect_zero("rst_now");
        next();
        expect_zero("rst_drop");

        // Release away from the clock edge; first sample lands one cycle later.
        drive_add(16'h7FFF, 16'h0001, 1'b0, 16'hABCD);
        rst_n = 1'b1;
        next();
        lit("post_rst", 16'hFFFE, 1'b1, 16'h0001, 16'hFFFF, 8'hCD);

        set_fields(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0);
        repeat (2) next();
        cmp_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_carry_width_stage
